// File: rtl/clamp_sat_stream.sv
// -----------------------------------------------------------------------------
// clamp_sat_stream
//
// Purpose
//   Streaming saturating narrower. Each beat carries CH signed INW-bit samples.
//   Each sample is clamped to an OUTW-bit range, either unsigned
//   (0 .. 2^OUTW-1) or signed (-2^(OUTW-1) .. 2^(OUTW-1)-1), as chosen by
//   `mode` in the cycle the beat is accepted. The result goes through a single
//   output register with valid/ready handshaking, so latency is one cycle and
//   throughput is one beat per cycle. Sticky per-channel flags and a
//   saturating event counter record saturation history.
//
// Ports
//   clk        in   1         sole clock, rising edge
//   rst        in   1         synchronous active-high reset
//   mode       in   1         0 = unsigned clamp, 1 = signed clamp
//   in_valid   in   1         input beat valid
//   in_ready   out  1         !out_valid || out_ready (combinational)
//   in_data    in   CH*INW    channel k at [k*INW +: INW], signed
//   out_valid  out  1         output beat valid
//   out_ready  in   1         downstream ready
//   out_data   out  CH*OUTW   channel k at [k*OUTW +: OUTW]
//   out_ovf    out  CH        channel clipped at the upper bound
//   out_unf    out  CH        channel clipped at the lower bound
//   clr_stat   in   1         clear sticky flags and sat_cnt (wins over update)
//   sticky_ovf out  CH        sticky upper-clip history
//   sticky_unf out  CH        sticky lower-clip history
//   sat_cnt    out  CNTW      accepted beats with any clipped channel, saturating
// -----------------------------------------------------------------------------
module clamp_sat_stream #(
    parameter int INW  = 16,
    parameter int OUTW = 8,
    parameter int CH   = 4,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*INW-1:0]    in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH*OUTW-1:0]   out_data,
    output logic [CH-1:0]        out_ovf,
    output logic [CH-1:0]        out_unf,
    input  logic                 clr_stat,
    output logic [CH-1:0]        sticky_ovf,
    output logic [CH-1:0]        sticky_unf,
    output logic [CNTW-1:0]      sat_cnt
);

    // The input needs at least one bit of headroom above the output so that
    // the unsigned upper bound 2^OUTW-1 is representable as a positive value.
    generate
        if (INW < OUTW + 1) begin : g_bad_width
            $error("clamp_sat_stream: INW must be >= OUTW+1");
        end
    endgenerate

    // Clamp bounds expressed in the input width (signed compare).
    localparam logic signed [INW-1:0] U_MAX = {{(INW-OUTW){1'b0}}, {OUTW{1'b1}}};
    localparam logic signed [INW-1:0] S_MAX = {{(INW-OUTW+1){1'b0}}, {(OUTW-1){1'b1}}};
    localparam logic signed [INW-1:0] S_MIN = {{(INW-OUTW+1){1'b1}}, {(OUTW-1){1'b0}}};

    // Saturated output codes.
    localparam logic [OUTW-1:0] U_HI = {OUTW{1'b1}};
    localparam logic [OUTW-1:0] U_LO = {OUTW{1'b0}};
    localparam logic [OUTW-1:0] S_HI = {1'b0, {(OUTW-1){1'b1}}};
    localparam logic [OUTW-1:0] S_LO = {1'b1, {(OUTW-1){1'b0}}};

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    logic                 out_valid_q, out_valid_d;
    logic [CH*OUTW-1:0]   out_data_q,  out_data_d;
    logic [CH-1:0]        out_ovf_q,   out_ovf_d;
    logic [CH-1:0]        out_unf_q,   out_unf_d;

    logic                 accept;
    logic                 handoff;

    // The register can take a new beat whenever it is empty or being drained
    // in this same cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid_q && out_ready;

    // -------------------------------------------------------------------------
    // Per-channel clamp (combinational, feeds only the output register)
    // -------------------------------------------------------------------------
    logic [CH*OUTW-1:0]   clamp_data;
    logic [CH-1:0]        clamp_ovf;
    logic [CH-1:0]        clamp_unf;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic signed [INW-1:0] x;
            logic [OUTW-1:0]       y;
            logic                  o;
            logic                  u;

            assign x = in_data[gi*INW +: INW];

            always_comb begin
                // In-range samples keep their low OUTW bits; the two's
                // complement encoding makes this correct for both modes.
                y = x[OUTW-1:0];
                o = 1'b0;
                u = 1'b0;
                if (!mode) begin
                    if (x[INW-1]) begin
                        y = U_LO;
                        u = 1'b1;
                    end else if (x > U_MAX) begin
                        y = U_HI;
                        o = 1'b1;
                    end
                end else begin
                    if (x > S_MAX) begin
                        y = S_HI;
                        o = 1'b1;
                    end else if (x < S_MIN) begin
                        y = S_LO;
                        u = 1'b1;
                    end
                end
            end

            assign clamp_data[gi*OUTW +: OUTW] = y;
            assign clamp_ovf[gi]               = o;
            assign clamp_unf[gi]               = u;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Output register next state
    // -------------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_unf_d   = out_unf_q;
        if (accept) begin
            // Covers both a fresh load and a simultaneous handoff+load.
            out_valid_d = 1'b1;
            out_data_d  = clamp_data;
            out_ovf_d   = clamp_ovf;
            out_unf_d   = clamp_unf;
        end else if (handoff) begin
            // Data and flags hold their last value once drained.
            out_valid_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Statistics next state
    // -------------------------------------------------------------------------
    logic [CH-1:0]   sticky_ovf_q, sticky_ovf_d;
    logic [CH-1:0]   sticky_unf_q, sticky_unf_d;
    logic [CNTW-1:0] sat_cnt_q,    sat_cnt_d;
    logic            beat_sat;

    assign beat_sat = |(clamp_ovf | clamp_unf);

    always_comb begin
        sticky_ovf_d = sticky_ovf_q;
        sticky_unf_d = sticky_unf_q;
        sat_cnt_d    = sat_cnt_q;
        if (clr_stat) begin
            // Clear wins: a beat accepted in the clear cycle is not recorded.
            sticky_ovf_d = '0;
            sticky_unf_d = '0;
            sat_cnt_d    = '0;
        end else if (accept) begin
            sticky_ovf_d = sticky_ovf_q | clamp_ovf;
            sticky_unf_d = sticky_unf_q | clamp_unf;
            if (beat_sat && (sat_cnt_q != CNT_MAX)) begin
                sat_cnt_d = sat_cnt_q + CNTW'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ovf_q    <= '0;
            out_unf_q    <= '0;
            sticky_ovf_q <= '0;
            sticky_unf_q <= '0;
            sat_cnt_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_ovf_q    <= out_ovf_d;
            out_unf_q    <= out_unf_d;
            sticky_ovf_q <= sticky_ovf_d;
            sticky_unf_q <= sticky_unf_d;
            sat_cnt_q    <= sat_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_ovf    = out_ovf_q;
    assign out_unf    = out_unf_q;
    assign sticky_ovf = sticky_ovf_q;
    assign sticky_unf = sticky_unf_q;
    assign sat_cnt    = sat_cnt_q;

endmodule

// File: tb/tb_clamp_sat_stream.sv
// -----------------------------------------------------------------------------
// tb_clamp_sat_stream
//
// Self-checking bench for clamp_sat_stream with INW=16, OUTW=8, CH=2, CNTW=4.
// A table of {mode, ch0, ch1, expected data/ovf/unf} records drives the main
// clamp cases; accepted beats push their expected result to a scoreboard
// queue which a negedge monitor compares against the output register while
// out_valid is high (repeatedly during stalls, so stability is checked too).
// Hand-written sequences cover backpressure, counter saturation, clear
// priority and mid-stream reset.
// -----------------------------------------------------------------------------
module tb_clamp_sat_stream;

    localparam int INW  = 16;
    localparam int OUTW = 8;
    localparam int CH   = 2;
    localparam int CNTW = 4;

    logic                clk;
    logic                rst;
    logic                mode;
    logic                in_valid;
    logic                in_ready;
    logic [CH*INW-1:0]   in_data;
    logic                out_valid;
    logic                out_ready;
    logic [CH*OUTW-1:0]  out_data;
    logic [CH-1:0]       out_ovf;
    logic [CH-1:0]       out_unf;
    logic                clr_stat;
    logic [CH-1:0]       sticky_ovf;
    logic [CH-1:0]       sticky_unf;
    logic [CNTW-1:0]     sat_cnt;

    clamp_sat_stream #(
        .INW  (INW),
        .OUTW (OUTW),
        .CH   (CH),
        .CNTW (CNTW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .out_unf    (out_unf),
        .clr_stat   (clr_stat),
        .sticky_ovf (sticky_ovf),
        .sticky_unf (sticky_unf),
        .sat_cnt    (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        m;
        logic [15:0] c0;
        logic [15:0] c1;
        logic [15:0] data;
        logic [1:0]  ovf;
        logic [1:0]  unf;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  ovf;
        logic [1:0]  unf;
    } exp_t;

    localparam int NVEC = 12;
    vec_t tbl [NVEC];
    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t to_exp(input vec_t v);
        exp_t e;
        e.data = v.data;
        e.ovf  = v.ovf;
        e.unf  = v.unf;
        return e;
    endfunction

    // Drive one beat; push its expectation on the cycle it is seen accepted.
    // Returns #1 after the accepting edge with in_valid and clr_stat dropped.
    task automatic send(input vec_t v, input logic clr);
        mode     = v.m;
        in_data  = {v.c1, v.c0};
        in_valid = 1'b1;
        clr_stat = clr;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(to_exp(v));
                $display("in  mode=%0d ch0=%h ch1=%h exp=%h ovf=%b unf=%b",
                         v.m, v.c0, v.c1, v.data, v.ovf, v.unf);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                clr_stat = 1'b0;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: in_ready never rose, expected acceptance within 50 cycles");
        in_valid = 1'b0;
        clr_stat = 1'b0;
    endtask

    task automatic check_idle_zero();
        check("rst_out_valid",  out_valid,  0);
        check("rst_out_data",   out_data,   0);
        check("rst_out_ovf",    out_ovf,    0);
        check("rst_out_unf",    out_unf,    0);
        check("rst_sticky_ovf", sticky_ovf, 0);
        check("rst_sticky_unf", sticky_unf, 0);
        check("rst_sat_cnt",    sat_cnt,    0);
    endtask

    task automatic pulse_clr();
        clr_stat = 1'b1;
        @(posedge clk);
        #1;
        clr_stat = 1'b0;
    endtask

    // Output monitor: compares the held beat against the scoreboard head
    // every cycle out_valid is high; pops on handoff.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            check("sb_has_entry", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                check("out_data",  out_data, sb_q[0].data);
                check("out_ovf",   out_ovf,  sb_q[0].ovf);
                check("out_unf",   out_unf,  sb_q[0].unf);
                check("ovf_unf_exclusive", out_ovf & out_unf, 0);
                if (out_ready) begin
                    $display("out data=%h ovf=%b unf=%b", out_data, out_ovf, out_unf);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    int         exp_sat;
    logic [1:0] exp_sovf;
    logic [1:0] exp_sunf;

    initial begin
        //           mode  ch0       ch1       data      ovf    unf
        tbl[0]  = '{1'b0, 16'h012C, 16'hFFF6, 16'h00FF, 2'b01, 2'b10};
        tbl[1]  = '{1'b1, 16'h0080, 16'hFF7F, 16'h807F, 2'b01, 2'b10};
        tbl[2]  = '{1'b1, 16'hFF80, 16'h007F, 16'h7F80, 2'b00, 2'b00};
        tbl[3]  = '{1'b0, 16'h00FF, 16'h0000, 16'h00FF, 2'b00, 2'b00};
        tbl[4]  = '{1'b0, 16'h0100, 16'hFFFF, 16'h00FF, 2'b01, 2'b10};
        tbl[5]  = '{1'b0, 16'h7FFF, 16'h8000, 16'h00FF, 2'b01, 2'b10};
        tbl[6]  = '{1'b0, 16'h0012, 16'h00AB, 16'hAB12, 2'b00, 2'b00};
        tbl[7]  = '{1'b1, 16'h7FFF, 16'h8000, 16'h807F, 2'b01, 2'b10};
        tbl[8]  = '{1'b1, 16'h0005, 16'hFFFB, 16'hFB05, 2'b00, 2'b00};
        tbl[9]  = '{1'b1, 16'hFF7F, 16'h0100, 16'h7F80, 2'b10, 2'b01};
        tbl[10] = '{1'b0, 16'h0080, 16'h0100, 16'hFF80, 2'b10, 2'b00};
        tbl[11] = '{1'b1, 16'h0000, 16'hFF81, 16'h8100, 2'b00, 2'b00};

        // Reset with in_valid and clr_stat asserted: both must be ignored.
        rst       = 1'b1;
        mode      = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0100_0300;
        clr_stat  = 1'b1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero();
        rst      = 1'b0;
        in_valid = 1'b0;
        clr_stat = 1'b0;
        check("in_ready_after_rst", in_ready, 1);
        out_ready = 1'b1;

        // Headline unsigned case: one-cycle latency and counter/sticky update.
        send(tbl[0], 1'b0);
        check("latency_out_valid", out_valid,  1);
        check("v038_sat_cnt",      sat_cnt,    1);
        check("v038_sticky_ovf",   sticky_ovf, 2'b01);
        check("v038_sticky_unf",   sticky_unf, 2'b10);
        pulse_clr();
        check("clr_sat_cnt", sat_cnt, 0);

        // Table sweep, back to back at full rate.
        exp_sat  = 0;
        exp_sovf = 2'b00;
        exp_sunf = 2'b00;
        for (int i = 0; i < NVEC; i++) begin
            send(tbl[i], 1'b0);
            if ((tbl[i].ovf | tbl[i].unf) != 2'b00) exp_sat++;
            exp_sovf = exp_sovf | tbl[i].ovf;
            exp_sunf = exp_sunf | tbl[i].unf;
        end
        check("tbl_sat_cnt",    sat_cnt,    exp_sat);
        check("tbl_sticky_ovf", sticky_ovf, exp_sovf);
        check("tbl_sticky_unf", sticky_unf, exp_sunf);
        repeat (2) @(posedge clk);
        #1;
        check("tbl_drained", out_valid, 0);

        // Backpressure: hold a saturating beat for 3 cycles while the next
        // beat waits and mode flips underneath the held beat.
        pulse_clr();
        out_ready = 1'b0;
        send(tbl[4], 1'b0);
        mode     = 1'b1;
        in_data  = {tbl[5].c1, tbl[5].c0};
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_sat_cnt",  sat_cnt,  1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(tbl[5], 1'b0);
        check("bp_reload_valid", out_valid, 1);
        check("bp_sat_cnt_end",  sat_cnt,   2);

        // Counter saturation at 2^CNTW-1.
        pulse_clr();
        for (int i = 0; i < 20; i++) send(tbl[0], 1'b0);
        check("cnt_sat_15", sat_cnt, 15);
        @(posedge clk);
        #1;
        check("cnt_sat_hold", sat_cnt, 15);

        // clr_stat in the accepting cycle of a saturating beat.
        send(tbl[1], 1'b0);
        send(tbl[4], 1'b1);
        check("clr_pri_sat_cnt",    sat_cnt,    0);
        check("clr_pri_sticky_ovf", sticky_ovf, 0);
        check("clr_pri_sticky_unf", sticky_unf, 0);
        check("clr_pri_out_ovf",    out_ovf,    2'b01);
        check("clr_pri_out_unf",    out_unf,    2'b10);
        @(posedge clk);
        #1;

        // Reset while a beat is held under backpressure.
        out_ready = 1'b0;
        send(tbl[7], 1'b0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = {tbl[9].c1, tbl[9].c0};
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        check_idle_zero();
        check("rst_mid_in_ready", in_ready, 1);

        // Normal operation resumes after reset.
        out_ready = 1'b1;
        send(tbl[2], 1'b0);
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        check("final_sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clamp_sat_stream.md
CLAMP_SAT_STREAM -- requirements
Module: clamp_sat_stream

Interface
REQ-001 Parameter INW, default 16: signed input sample width per channel.
REQ-002 Parameter OUTW, default 8: output sample width per channel; INW >= OUTW+1 is required, and elaboration SHALL fail otherwise.
REQ-003 Parameter CH, default 4: number of parallel channels per beat.
REQ-004 Parameter CNTW, default 16: width of the saturation event counter.
REQ-005 clk  in  1  sole clock; all state changes on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 mode  in  1  clamp mode, sampled per accepted beat: 0 = unsigned 0..2^OUTW-1; 1 = signed -2^(OUTW-1)..2^(OUTW-1)-1.
REQ-008 in_valid  in  1  input beat valid.
REQ-009 in_ready  out  1  block accepts a beat when in_valid && in_ready.
REQ-010 in_data  in  CH*INW  signed samples; channel k occupies bits [k*INW +: INW].
REQ-011 out_valid  out  1  output beat valid.
REQ-012 out_ready  in  1  downstream accepts when out_valid && out_ready.
REQ-013 out_data  out  CH*OUTW  clamped samples; channel k occupies bits [k*OUTW +: OUTW].
REQ-014 out_ovf  out  CH  per-channel flag: the beat clipped at the upper bound.
REQ-015 out_unf  out  CH  per-channel flag: the beat clipped at the lower bound.
REQ-016 clr_stat  in  1  single-cycle clear of the statistics.
REQ-017 sticky_ovf, sticky_unf  out  CH each  sticky per-channel saturation history.
REQ-018 sat_cnt  out  CNTW  count of accepted beats with at least one saturated channel.

Function
REQ-019 Transfer: one pipeline register; latency is exactly 1 cycle from input acceptance to out_valid.
REQ-020 in_ready SHALL equal !out_valid || out_ready (combinational); full throughput is 1 beat per cycle.
REQ-021 Accept without output handoff: out_valid <= 1; out_data and the out flags load the clamp result.
REQ-022 Output handoff without accept: out_valid <= 0; out_data and the out flags hold their last value.
REQ-023 Handoff and accept in the same cycle: the new beat loads and out_valid stays 1.
REQ-024 While out_valid && !out_ready, out_data, out_ovf and out_unf SHALL remain stable.
REQ-025 Mode 0, per channel:
  - x < 0 -> 0 with unf=1;
  - x > 2^OUTW-1 -> all ones with ovf=1;
  - otherwise x[OUTW-1:0] with no flag.
REQ-026 Mode 1, per channel:
  - x > 2^(OUTW-1)-1 -> {0, all ones} with ovf=1;
  - x < -2^(OUTW-1) -> {1, all zeros} with unf=1;
  - otherwise x[OUTW-1:0] with no flag.
REQ-027 The exact bounds pass unflagged: 255 and 0 in mode 0; 127 and -128 in mode 1 (OUTW=8).
REQ-028 ovf and unf SHALL never both be set for a channel.
REQ-029 The mode applied to a beat is the value of mode in its acceptance cycle; mode changes never alter a beat already held.
REQ-030 Statistics update only on acceptance cycles:
  - sticky_ovf |= beat ovf; sticky_unf |= beat unf;
  - sat_cnt += 1 if any channel flagged.
REQ-031 sat_cnt SHALL saturate at 2^CNTW-1 and never wrap.
REQ-032 clr_stat zeroes the sticky flags and sat_cnt next cycle; it has priority, so a saturated beat accepted in the same cycle is not recorded.
REQ-033 clr_stat SHALL not affect the data path, out_valid or the out flags.
REQ-034 No combinational path from in_data or mode to any output.

Reset
REQ-035 While rst=1 at a clock edge, the block SHALL:
  - set out_valid=0, out_data=0, out_ovf=0, out_unf=0;
  - set sticky_ovf=0, sticky_unf=0, sat_cnt=0;
  - ignore in_valid and clr_stat.
REQ-036 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-037 Reset mid-operation discards any held beat; no partial beat appears after reset.

Verification (INW=16, OUTW=8, CH=2 unless stated)
REQ-038 Mode 0, in_data ch0=0x012C (300), ch1=0xFFF6 (-10), out_ready=1 -> next cycle out_data={0x00,0xFF}, out_ovf=2'b01, out_unf=2'b10, sat_cnt=1.
REQ-039 Mode 1, ch0=0x0080 then 0xFF80, ch1=0xFF7F then 0x007F -> beat 1 {0x80,0x7F} with ovf=01, unf=10; beat 2 {0x7F,0x80} with no flags; sat_cnt=1.
REQ-040 Backpressure: a saturating beat accepted, out_ready=0 for 3 cycles -> in_ready=0, out_data stable, sat_cnt=1 (not 4); out_ready=1 then completes the handoff.
REQ-041 CNTW=4: 20 consecutive saturating beats -> sat_cnt=15 and holds.
REQ-042 clr_stat asserted in the same cycle a saturating beat is accepted -> sat_cnt=0 and sticky flags 0; out_ovf still reflects the beat.
REQ-043 rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, all outputs 0, in_ready=1.
